// File: rtl/data_mem_stq.sv
// Dual-slot data memory: a single-write-port RAM plus an in-order store queue
// that absorbs the second store of a cycle, with store-to-load forwarding.
module data_mem_stq #(
    parameter int DEPTH  = 64,
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        memwrite2,
    input  logic [31:0] dataadr,
    input  logic [31:0] dataadr2,
    input  logic [31:0] writedata,
    input  logic [31:0] writedata2,
    output logic [31:0] readdata,
    output logic [31:0] readdata2,
    output logic        stall
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]   r_ram   [DEPTH];
    logic [AW-1:0] r_q_adr [QDEPTH];
    logic [31:0]   r_q_dat [QDEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [AW-1:0] w_idx1;
    logic [AW-1:0] w_idx2;
    logic          w_empty;
    logic          w_accept;
    logic          w_drain;
    logic          w_direct1;
    logic          w_direct2;
    logic          w_enq1;
    logic          w_enq2;
    logic [PW-1:0] w_tail1;
    logic [PW-1:0] w_p;
    logic [31:0]   w_rd1;
    logic [31:0]   w_rd2;
    logic          w_unused_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_idx1        = dataadr[AW+1:2];
    assign w_idx2        = dataadr2[AW+1:2];
    assign w_unused_bits = ^{dataadr[31:AW+2], dataadr[1:0], dataadr2[31:AW+2], dataadr2[1:0]};

    assign stall     = (r_count == CW'(QDEPTH));
    assign w_empty   = (r_count == '0);
    assign w_accept  = !stall;
    assign w_drain   = !w_empty;
    // With an empty queue slot 1 (or a lone slot 2) owns the RAM port this cycle.
    assign w_direct1 = w_accept && w_empty && memwrite;
    assign w_direct2 = w_accept && w_empty && memwrite2 && !memwrite;
    assign w_enq1    = w_accept && !w_empty && memwrite;
    assign w_enq2    = w_accept && memwrite2 && (!w_empty || memwrite);
    assign w_tail1   = w_enq1 ? ptr_inc(r_tail) : r_tail;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        w_rd1 = r_ram[w_idx1];
        w_rd2 = r_ram[w_idx2];
        w_p   = r_head;
        for (int i = 0; i < QDEPTH; i++) begin
            if (int'(r_count) > i) begin
                if (r_q_adr[w_p] == w_idx1) w_rd1 = r_q_dat[w_p];
                if (r_q_adr[w_p] == w_idx2) w_rd2 = r_q_dat[w_p];
            end
            w_p = ptr_inc(w_p);
        end
        if (memwrite && (w_idx1 == w_idx2)) w_rd2 = writedata;
    end

    assign readdata  = w_rd1;
    assign readdata2 = w_rd2;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_ram[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_drain)        r_ram[r_q_adr[r_head]] <= r_q_dat[r_head];
            else if (w_direct1) r_ram[w_idx1] <= writedata;
            else if (w_direct2) r_ram[w_idx2] <= writedata2;

            if (w_enq1) begin
                r_q_adr[r_tail] <= w_idx1;
                r_q_dat[r_tail] <= writedata;
            end
            if (w_enq2) begin
                r_q_adr[w_tail1] <= w_idx2;
                r_q_dat[w_tail1] <= writedata2;
            end

            r_tail  <= w_enq2 ? ptr_inc(w_tail1) : w_tail1;
            if (w_drain) r_head <= ptr_inc(r_head);
            r_count <= r_count - CW'(w_drain) + CW'(w_enq1) + CW'(w_enq2);
        end
    end
endmodule

// File: doc/data_mem_stq.md
DATA_MEM_STQ -- requirements
Module: data_mem_stq

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit RAM words; word index = address[log2(DEPTH)+1:2].
REQ-002 SHALL have parameter QDEPTH, default 2, meaning store-queue entries (at least 2).
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 memwrite  input  1  slot-1 (older) store request.
REQ-006 memwrite2  input  1  slot-2 (younger) store request.
REQ-007 dataadr  input  32  slot-1 byte address; address[1:0] ignored.
REQ-008 dataadr2  input  32  slot-2 byte address; address[1:0] ignored.
REQ-009 writedata  input  32  slot-1 store data.
REQ-010 writedata2  input  32  slot-2 store data.
REQ-011 readdata  output  32  slot-1 load data, combinational.
REQ-012 readdata2  output  32  slot-2 load data, combinational.
REQ-013 stall  output  1  high = queue full, core shall hold both store slots.

Function
REQ-014 RAM SHALL accept exactly one write per cycle; second same-cycle store is buffered in an in-order FIFO store queue of QDEPTH entries (address, data).
REQ-015 Program order SHALL be: queued entries (oldest first), then slot 1, then slot 2.
REQ-016 Queue empty: slot-1 store writes RAM directly at the edge; slot-2 store enqueues; a lone slot-2 store writes RAM directly.
REQ-017 Queue non-empty: head entry drains to RAM at the edge; every new store (slot 1 then slot 2) enqueues at tail.
REQ-018 Count update SHALL be count_next = count - drain + enqueued; net growth never exceeds +1 per cycle.
REQ-019 stall SHALL be combinational: high exactly when count == QDEPTH.
REQ-020 Stores presented while stall is high SHALL be discarded (no RAM or queue change); draining continues.
REQ-021 readdata SHALL return the youngest queue entry with matching word index, else RAM word.
REQ-022 readdata2 SHALL return writedata when memwrite is high and word indices match, else youngest matching queue entry, else RAM word.
REQ-023 Loads SHALL never see the same-cycle slot-2 store.
REQ-024 Same-cycle slot-1 and slot-2 stores to one word: slot-2 value SHALL be the final RAM content.
REQ-025 Address bits above the word index SHALL be ignored (wrap modulo DEPTH).
REQ-026 Queue pointers SHALL wrap modulo QDEPTH.

Reset
REQ-027 On reset high at an edge: all RAM words = 0, queue empty (count 0, pointers 0), regardless of pending stores or queued entries.
REQ-028 After reset: stall = 0, readdata = readdata2 = 0 for every address.
REQ-029 Stores presented in the reset cycle SHALL be discarded.

Verification
REQ-030 Reset, then slot-1 store 0x11 to 0x04 and slot-2 store 0x22 to 0x08 -> next cycle count 1, readdata2 @0x08 = 0x22 (queue); cycle after: count 0, RAM[2] = 0x22.
REQ-031 Same cycle slot-1 store 0xAA to 0x10, slot-2 load 0x10 -> readdata2 = 0xAA combinationally; slot-1 load 0x10 shows old value 0.
REQ-032 Both slots store to 0x20 (0x1, 0x2) -> after drain RAM[8] = 0x2; intermediate load 0x20 returns 0x2.
REQ-033 QDEPTH=2: three consecutive dual-store cycles -> count 1, 2; stall high in third cycle; third-cycle stores discarded; stall drops after next drain.
REQ-034 Queue holding two entries, reset asserted -> next cycle count 0, stall 0, all loads return 0.
REQ-035 Store 0x5 to address 0x104 with DEPTH=64 -> load 0x004 returns 0x5 (wrap).
